// File: rtl/tx_lane_scheduler.sv
// Round-robin byte scheduler feeding the TX serializer: four requesters, bounded bursts, COM idle fill.
// Define SKP_INSERT_EN to build periodic SKP ordered-set insertion at burst boundaries.
module tx_lane_scheduler #(
  parameter int MAX_BURST    = 8,
  parameter int SKP_INTERVAL = 256
) (
  input  logic        clk_4f,
  input  logic        reset_L,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  output logic [3:0]  req_ready,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic        skp_out,
  output logic [1:0]  lane_id
);

  localparam logic [7:0] COM = 8'hBC;

  if (MAX_BURST < 1 || MAX_BURST > 255 || SKP_INTERVAL < 8 || SKP_INTERVAL > 65535) begin : g_bad_param
    $error("tx_lane_scheduler: parameter out of range");
  end

`ifdef SKP_INSERT_EN
  localparam logic [7:0] SKP_SYM = 8'h1C;
  typedef enum logic [1:0] {IDLE, SEND, SKP} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

  state_t     state, state_next;
  logic [1:0] grant, grant_next;
  logic [1:0] rr_ptr, rr_ptr_next;
  logic [7:0] burst_cnt, burst_cnt_next;
  logic [7:0] data_next;
  logic       valid_next;
  logic [1:0] lane_next;
  logic [1:0] pick;
  logic       skp_busy;
  logic       xfer;
  logic       send_exit;

`ifdef SKP_INSERT_EN
  logic [15:0] skp_cnt;
  logic        skp_pending;
  logic [1:0]  skp_idx;
  logic        skp_expire;
  logic        skp_enter;
  logic        skp_next;

  assign skp_busy   = skp_pending;
  assign skp_expire = (skp_cnt == 16'(SKP_INTERVAL - 1));
  assign skp_enter  = (state_next == SKP) && (state != SKP);

  // An expiry while a request is still outstanding is dropped, never queued.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      skp_cnt     <= 16'd0;
      skp_pending <= 1'b0;
      skp_idx     <= 2'd3;
      skp_out     <= 1'b0;
    end else begin
      skp_cnt     <= skp_expire ? 16'd0 : skp_cnt + 16'd1;
      skp_pending <= skp_enter ? 1'b0 : (skp_pending | skp_expire);
      skp_idx     <= (state == SKP) ? skp_idx - 2'd1 : 2'd3;
      skp_out     <= skp_next;
    end
  end
`else
  assign skp_busy = 1'b0;
  assign skp_out  = 1'b0;
`endif

  // Ready depends on registers only, so requesters see no combinational loop.
  for (genvar gi = 0; gi < 4; gi++) begin : g_ready
    assign req_ready[gi] = (state == SEND) && !skp_busy && (grant == 2'(gi));
  end

  assign xfer      = (state == SEND) && req_valid[grant] && !skp_busy;
  assign send_exit = (xfer && (burst_cnt == 8'(MAX_BURST - 1))) || !req_valid[grant] || skp_busy;

  // First valid requester at or after rr_ptr, modulo 4.
  always_comb begin
    pick = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req_valid[rr_ptr + 2'(k)]) pick = rr_ptr + 2'(k);
    end
  end

  always_comb begin
    state_next     = state;
    grant_next     = grant;
    rr_ptr_next    = rr_ptr;
    burst_cnt_next = burst_cnt;
    data_next      = COM;
    valid_next     = 1'b0;
    lane_next      = 2'd0;
`ifdef SKP_INSERT_EN
    skp_next       = 1'b0;
`endif
    case (state)
      IDLE: begin
`ifdef SKP_INSERT_EN
        if (skp_pending) state_next = SKP;
        else
`endif
        if (|req_valid) begin
          grant_next     = pick;
          burst_cnt_next = 8'd0;
          state_next     = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          data_next      = req_data[8*grant +: 8];
          valid_next     = 1'b1;
          lane_next      = grant;
          burst_cnt_next = burst_cnt + 8'd1;
        end
        if (send_exit) begin
          rr_ptr_next = grant + 2'd1;
`ifdef SKP_INSERT_EN
          state_next  = skp_pending ? SKP : IDLE;
`else
          state_next  = IDLE;
`endif
        end
      end
`ifdef SKP_INSERT_EN
      SKP: begin
        data_next  = (skp_idx == 2'd3) ? COM : SKP_SYM;
        valid_next = 1'b1;
        skp_next   = 1'b1;
        if (skp_idx == 2'd0) state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      state     <= IDLE;
      grant     <= 2'd0;
      rr_ptr    <= 2'd0;
      burst_cnt <= 8'd0;
      data_out  <= COM;
      valid_out <= 1'b0;
      lane_id   <= 2'd0;
    end else begin
      state     <= state_next;
      grant     <= grant_next;
      rr_ptr    <= rr_ptr_next;
      burst_cnt <= burst_cnt_next;
      data_out  <= data_next;
      valid_out <= valid_next;
      lane_id   <= lane_next;
    end
  end

endmodule

// File: tb/tb_tx_lane_scheduler.sv
// Self-checking bench for tx_lane_scheduler: directed scenarios plus randomized traffic against a cycle model.
module tb_tx_lane_scheduler;
  localparam int MAXB = 8;
  localparam int SKPI = 16;

  logic        clk_4f = 1'b0;
  logic        reset_L = 1'b1;
  logic [3:0]  req_valid = 4'd0;
  logic [31:0] req_data = 32'd0;
  logic [3:0]  req_ready;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        skp_out;
  logic [1:0]  lane_id;

  always #5 clk_4f = ~clk_4f;

  tx_lane_scheduler #(.MAX_BURST(MAXB), .SKP_INTERVAL(SKPI)) dut (
    .clk_4f(clk_4f), .reset_L(reset_L), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .data_out(data_out), .valid_out(valid_out),
    .skp_out(skp_out), .lane_id(lane_id)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  bq [4][$];
  bit          en [4];
  logic [11:0] rec [$];
  int          run_lane [$];
  int          run_len [$];
  logic [7:0]  bytes_seen [$];

  // Behavioural model: phase 0 = arbitrating, 1 = serving owner, 2 = SKP set.
  int         m_phase, m_owner, m_next, m_count, m_tick, m_left;
  bit         m_due;
  logic [7:0] m_data;
  bit         m_valid, m_skp;
  int         m_lane;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] m_ready();
    return (m_phase == 1 && !m_due) ? 4'(1 << m_owner) : 4'b0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_next = 0; m_count = 0; m_tick = 0; m_left = 0; m_due = 0;
    m_data = 8'hBC; m_valid = 0; m_skp = 0; m_lane = 0;
  endtask

  task automatic model_edge(input logic [3:0] v, input logic [31:0] d);
    logic [3:0] r;
    bit expire, entering;
    r = m_ready();
    expire = 0;
    entering = 0;
`ifdef SKP_INSERT_EN
    expire = (m_tick == SKPI - 1);
    m_tick = expire ? 0 : m_tick + 1;
`endif
    m_data = 8'hBC; m_valid = 0; m_skp = 0; m_lane = 0;
    case (m_phase)
      0: begin
        if (m_due) begin
          m_phase = 2; m_left = 4; entering = 1;
        end else if (v != 4'd0) begin
          for (int k = 0; k < 4; k++) begin
            if (v[(m_next + k) % 4]) begin
              m_owner = (m_next + k) % 4;
              break;
            end
          end
          m_count = 0;
          m_phase = 1;
        end
      end
      1: begin
        if (v[m_owner] && r[m_owner]) begin
          m_data = d[8*m_owner +: 8]; m_valid = 1; m_lane = m_owner; m_count++;
        end
        if (m_count == MAXB || !v[m_owner] || m_due) begin
          m_next = (m_owner + 1) % 4;
          if (m_due) begin
            m_phase = 2; m_left = 4; entering = 1;
          end else begin
            m_phase = 0;
          end
        end
      end
      default: begin
        m_data = (m_left == 4) ? 8'hBC : 8'h1C;
        m_valid = 1; m_skp = 1; m_left--;
        if (m_left == 0) m_phase = 0;
      end
    endcase
    m_due = entering ? 1'b0 : (m_due | expire);
  endtask

  task automatic drive();
    logic [3:0] v;
    logic [31:0] d;
    v = 4'd0;
    d = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (bq[i].size() > 0) begin
        d[8*i +: 8] = bq[i][0];
        v[i] = en[i];
      end
    end
    req_valid = v;
    req_data = d;
  endtask

  task automatic cycle();
    logic [3:0] fire;
    @(negedge clk_4f);
    chk("data_out", 32'(data_out), 32'(m_data));
    chk("valid_out", 32'(valid_out), 32'(m_valid));
    chk("skp_out", 32'(skp_out), 32'(m_skp));
    chk("lane_id", 32'(lane_id), 32'(m_lane));
    chk("req_ready", 32'(req_ready), 32'(m_ready()));
    rec.push_back({skp_out, valid_out, lane_id, data_out});
    fire = req_valid & req_ready;
    model_edge(req_valid, req_data);
    @(posedge clk_4f);
    #1;
    for (int i = 0; i < 4; i++) if (fire[i] && bq[i].size() > 0) void'(bq[i].pop_front());
    drive();
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bq[i].delete();
      en[i] = 0;
    end
    drive();
    model_reset();
    #2;
    for (int n = 0; n < 2; n++) begin
      chk("rst_data", 32'(data_out), 32'hBC);
      chk("rst_valid", 32'(valid_out), 32'd0);
      chk("rst_skp", 32'(skp_out), 32'd0);
      chk("rst_lane", 32'(lane_id), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      @(posedge clk_4f);
      #1;
    end
    reset_L = 1'b1;
    rec.delete();
  endtask

  task automatic build_runs();
    int cur;
    int last;
    run_lane.delete();
    run_len.delete();
    bytes_seen.delete();
    cur = 0;
    last = 0;
    foreach (rec[i]) begin
      if (rec[i][10] && !rec[i][11]) begin
        bytes_seen.push_back(rec[i][7:0]);
        if (cur > 0 && int'(rec[i][9:8]) == last) cur++;
        else begin
          if (cur > 0) begin run_lane.push_back(last); run_len.push_back(cur); end
          cur = 1;
          last = int'(rec[i][9:8]);
        end
      end else begin
        if (cur > 0) begin run_lane.push_back(last); run_len.push_back(cur); end
        cur = 0;
      end
    end
    if (cur > 0) begin run_lane.push_back(last); run_len.push_back(cur); end
  endtask

  initial begin
    int nvalid;
    int nskp;
    model_reset();
    drive();
    #1;

    // Reset with no requests, then idle COM after release.
    do_reset();
    repeat (6) cycle();

    // Requester 2 streams 20 bytes.
    do_reset();
    for (int k = 1; k <= 20; k++) bq[2].push_back(8'(k));
    en[2] = 1;
    drive();
    repeat (40) cycle();
    build_runs();
    chk("r2_count", 32'(bytes_seen.size()), 32'd20);
    foreach (bytes_seen[i]) chk("r2_order", 32'(bytes_seen[i]), 32'(i + 1));
`ifndef SKP_INSERT_EN
    chk("r2_runs", 32'(run_len.size()), 32'd3);
    foreach (run_len[i]) begin
      chk("r2_len", 32'(run_len[i]), (i < 2) ? 32'd8 : 32'd4);
      chk("r2_lane", 32'(run_lane[i]), 32'd2);
    end
`endif

    // All four constantly valid.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 40; k++) bq[i].push_back(8'(i * 64 + k));
      en[i] = 1;
    end
    drive();
    repeat (50) cycle();
    build_runs();
`ifndef SKP_INSERT_EN
    chk("rr_runs_ge5", 32'(run_len.size() >= 5), 32'd1);
    for (int i = 0; i < 5 && i < run_len.size(); i++) begin
      chk("rr_lane", 32'(run_lane[i]), 32'(i % 4));
      chk("rr_len", 32'(run_len[i]), 32'd8);
    end
`endif

    // Reset asserted mid-burst, then arbitration restarts at requester 0.
    do_reset();
    for (int k = 0; k < 20; k++) bq[1].push_back(8'(8'h40 + k));
    en[1] = 1;
    drive();
    nvalid = 0;
    for (int n = 0; n < 40 && nvalid < 5; n++) begin
      cycle();
      if (rec[rec.size() - 1][10]) nvalid++;
    end
    chk("mid_burst_reached", 32'(nvalid), 32'd5);
    chk("mid_burst_valid", 32'(valid_out), 32'd1);
    do_reset();
    for (int k = 0; k < 6; k++) begin
      bq[0].push_back(8'(8'h80 + k));
      bq[3].push_back(8'(8'hC0 + k));
    end
    en[0] = 1;
    en[3] = 1;
    drive();
    repeat (20) cycle();
    build_runs();
    chk("post_rst_runs", 32'(run_lane.size() > 0), 32'd1);
    if (run_lane.size() > 0) chk("post_rst_first_lane", 32'(run_lane[0]), 32'd0);

    // Requester 1 drops after 3 bytes; requester 2 takes over.
    do_reset();
    for (int k = 0; k < 3; k++) bq[1].push_back(8'(8'h10 + k));
    for (int k = 0; k < 5; k++) bq[2].push_back(8'(8'h20 + k));
    en[1] = 1;
    en[2] = 1;
    drive();
    repeat (25) cycle();
    build_runs();
`ifndef SKP_INSERT_EN
    chk("drop_runs", 32'(run_len.size()), 32'd2);
    if (run_len.size() == 2) begin
      chk("drop_lane0", 32'(run_lane[0]), 32'd1);
      chk("drop_len0", 32'(run_len[0]), 32'd3);
      chk("drop_lane1", 32'(run_lane[1]), 32'd2);
      chk("drop_len1", 32'(run_len[1]), 32'd5);
    end
`endif

`ifdef SKP_INSERT_EN
    // Requester 0 streaming across several SKP intervals.
    do_reset();
    for (int k = 0; k < 60; k++) bq[0].push_back(8'(k));
    en[0] = 1;
    drive();
    repeat (90) cycle();
    build_runs();
    nskp = 0;
    foreach (rec[i]) if (rec[i][11]) nskp++;
    chk("skp_seen", 32'(nskp >= 8 && nskp % 4 == 0), 32'd1);
    foreach (bytes_seen[i]) chk("skp_cont", 32'(bytes_seen[i]), 32'(i));
`else
    nskp = 0;
`endif

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (bq[i].size() < 10 && $urandom_range(0, 3) == 0) bq[i].push_back(8'($urandom));
        en[i] = ($urandom_range(0, 9) < 8);
      end
      drive();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_lane_scheduler.md
# tx_lane_scheduler

- Shares the single byte input of the transmit parallel-to-serial serializer among four byte-stream requesters.
- Runs at the byte clock, clk_4f.
- Grants requesters round-robin in bounded bursts and drives COM (8'hBC) idle bytes when nobody is sending.
- Optionally inserts periodic SKP ordered sets (COM, SKP, SKP, SKP) at burst boundaries.

## Interface
- MAX_BURST, 8: maximum bytes per grant before rotation; range 1–255.
- SKP_INTERVAL, 256: clk_4f cycles between SKP requests; range 8–65535.
- clk_4f  input  1  byte clock; all logic on its rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- req_valid  input  4  requester i has a byte on req_data[8i+7:8i].
- req_data  input  32  four packed bytes, requester 0 in bits [7:0].
- req_ready  output  4  one-hot or zero; byte i transfers when req_valid[i] and req_ready[i] are both high at a clk_4f edge.
- data_out  output  8  byte to the serializer data input.
- valid_out  output  1  to the serializer valid input; 0 means idle (COM).
- skp_out  output  1  high while data_out carries an SKP ordered-set byte.
- lane_id  output  2  source requester of data_out; 0 when not valid.

## Operation
- FSM states: IDLE, SEND, SKP. Registers: grant[1:0], rr_ptr[1:0], burst_cnt (8 bit), skp_cnt (16 bit), skp_pending, skp_idx[1:0].
- IDLE:
  - If skp_pending, go to SKP.
  - Otherwise, if any req_valid, set grant to the first requester with req_valid high, searching from rr_ptr upward modulo 4, and go to SEND with burst_cnt=0.
  - Otherwise, stay in IDLE.
  - Outputs while in IDLE: data_out=8'hBC, valid_out=0, skp_out=0, lane_id=0.
- SEND:
  - req_ready[grant] = !skp_pending. This is combinational from registers only, with no path from req_valid.
  - On a transfer: burst_cnt+1; the byte is registered to data_out with valid_out=1 and lane_id=grant.
  - A cycle with no transfer registers an idle COM.
  - Exit when any of these holds: burst_cnt reaches MAX_BURST; req_valid[grant]=0; skp_pending=1.
  - Exit actions: rr_ptr=grant+1 (wraps 3→0), then go to SKP if skp_pending, else IDLE.
  - The last transfer and the exit occur on the same edge.
- SKP:
  - Emit 8'hBC, 8'h1C, 8'h1C, 8'h1C on four consecutive cycles, with valid_out=1 and skp_out=1.
  - req_ready=0 throughout.
  - skp_idx 3→0 then return to IDLE.
  - skp_pending clears on SKP entry.
- skp_cnt:
  - Increments every cycle.
  - At SKP_INTERVAL−1, sets skp_pending and reloads to 0.
  - A new interval expiry while skp_pending is already set is dropped; requests do not queue.
- Reset (asynchronous, any state, mid-burst included):
  - state=IDLE; grant=0, rr_ptr=0, burst_cnt=0, skp_cnt=0, skp_pending=0.
  - req_ready=0, data_out=8'hBC, valid_out=0, skp_out=0, lane_id=0.
  - A byte in flight is lost; requesters must re-present it.

## Timing
- Arbitration: one cycle in IDLE; the first req_ready is high in the cycle after IDLE sees req_valid.
- Data latency: the byte accepted at edge N appears on data_out after edge N, held for one cycle.
- Throughput: up to MAX_BURST consecutive bytes per grant. Minimum gap between grants is one idle COM cycle, the IDLE arbitration cycle.
- SKP latency:
  - Seen in SEND: the first SKP byte appears on data_out 2 cycles after skp_pending sets.
  - Seen in IDLE: the first SKP byte appears 2 cycles after skp_pending sets.
  - No byte is dropped or duplicated around an SKP.
- Simultaneous events:
  - A requester that is the current grant and asserts again is served only after the others, per rr_ptr.
  - skp_pending set on the same edge as burst-end selects SKP.

## Configuration
- SKP_INSERT_EN defined: SKP scheduling as above.
- SKP_INSERT_EN undefined:
  - skp_cnt, skp_pending, skp_idx and the SKP state are not built.
  - skp_out is tied to 0; req_ready[grant] is 1 throughout SEND.
  - Behaviour is otherwise identical.

## Test plan
- Reset with all req_valid=0 → data_out=8'hBC, valid_out=0, req_ready=0 continuously; after release, idle COM every cycle.
- Requester 2 only, streaming 8'h01..8'h14 (20 bytes), MAX_BURST=8:
  - Output is bursts of 8, 8, 4 with one COM gap between bursts.
  - Order preserved; lane_id=2 on every valid byte.
- All four requesters constantly valid → grants 0,1,2,3,0 in order, each exactly 8 bytes; no requester ever starved.
- SKP_INSERT_EN defined, SKP_INTERVAL=16, requester 0 streaming:
  - An SKP set BC,1C,1C,1C with skp_out=1 appears each interval at a burst boundary.
  - The data sequence is continuous across each SKP.
- Assert reset_L=0 mid-burst (byte 5 of 8) → outputs take reset values immediately, without waiting for a clock edge; after release, arbitration restarts at requester 0.
- Requester 1 drops req_valid after 3 bytes → SEND exits, next grant goes to requester 2 if valid, otherwise the block idles.
